lif_neuron: RTL and testbench



---
 rtl/lif_neuron.sv | 80 ++++++++
 tb/tb_lif_neuron.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates signed input current into an
// 8-bit potential with constant leak, fires a one-cycle spike, then goes refractory.
module lif_neuron (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [4:0] input_current,
  input  logic [7:0] threshold,
  input  logic [3:0] decay,
  input  logic [3:0] refractory_period,
  output logic       spike_out,
  output logic [7:0] membrane_potential,
  output logic       refractory_active
);

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  logic [7:0]        v_q, v_d;
  logic [3:0]        ref_cnt_q, ref_cnt_d;
  logic              spike_q, spike_d;
  logic signed [9:0] sum;
  logic [7:0]        clamped;
  state_t            state;

  // The mode is fully implied by the refractory counter, so no separate state flop.
  assign state = (ref_cnt_q != 4'd0) ? REFRACTORY : INTEGRATE;

  always_comb begin
    sum = $signed({2'b00, v_q})
        + $signed({{5{input_current[4]}}, input_current})
        - $signed({6'b000000, decay});
    if (sum[9])
      clamped = 8'd0;
    else if (sum[8])
      clamped = 8'd255;
    else
      clamped = sum[7:0];
  end

  always_comb begin
    v_d       = v_q;
    ref_cnt_d = ref_cnt_q;
    spike_d   = 1'b0;
    if (enable) begin
      case (state)
        REFRACTORY: begin
          ref_cnt_d = ref_cnt_q - 4'd1;
          v_d       = 8'd0;
        end
        default: begin
          // A zero threshold fires on every step; no special case needed.
          if (clamped >= threshold) begin
            spike_d   = 1'b1;
            v_d       = 8'd0;
            ref_cnt_d = refractory_period;
          end else begin
            v_d = clamped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q       <= 8'd0;
      ref_cnt_q <= 4'd0;
      spike_q   <= 1'b0;
    end else begin
      v_q       <= v_d;
      ref_cnt_q <= ref_cnt_d;
      spike_q   <= spike_d;
    end
  end

  assign spike_out          = spike_q;
  assign membrane_potential = v_q;
  assign refractory_active  = (ref_cnt_q != 4'd0);

endmodule

// File: tb/tb_lif_neuron.sv
// Testbench for lif_neuron: directed scenarios plus randomized steps checked
// against an integer-arithmetic behavioural model.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [4:0] input_current;
  logic [7:0] threshold;
  logic [3:0] decay;
  logic [3:0] refractory_period;
  logic       spike_out;
  logic [7:0] membrane_potential;
  logic       refractory_active;

  int total = 0;
  int bad   = 0;

  // Reference model state: potential, remaining ignored steps, last spike.
  int m_v;
  int m_rc;
  int m_spk;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .input_current     (input_current),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .spike_out         (spike_out),
    .membrane_potential(membrane_potential),
    .refractory_active (refractory_active)
  );

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".spike"}, {31'd0, spike_out}, m_spk);
    check_val({tag, ".v"}, {24'd0, membrane_potential}, m_v);
    check_val({tag, ".refr"}, {31'd0, refractory_active}, (m_rc > 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_v   = 0;
    m_rc  = 0;
    m_spk = 0;
  endtask

  // One time step described directly in terms of neuron behaviour.
  task automatic model_step(input bit en, input int cur);
    int s;
    m_spk = 0;
    if (!en) return;
    if (m_rc > 0) begin
      m_rc = m_rc - 1;
      m_v  = 0;
      return;
    end
    s = m_v + cur - int'(decay);
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    if (s >= int'(threshold)) begin
      m_spk = 1;
      m_v   = 0;
      m_rc  = int'(refractory_period);
    end else begin
      m_v = s;
    end
  endtask

  task automatic set_cfg(input int thr, input int dec, input int rp);
    threshold         = thr[7:0];
    decay             = dec[3:0];
    refractory_period = rp[3:0];
  endtask

  task automatic apply_step(input string tag, input bit en, input int cur);
    enable        = en;
    input_current = cur[4:0];
    @(posedge clk);
    model_step(en, cur);
    #1;
    check_outputs(tag);
  endtask

  // Reset is asserted between edges to prove it acts without a clock.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    input_current = 5'd0;
    set_cfg(100, 1, 0);
    model_reset();
    #1;
    check_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Integration with leak, then negative current clamping at zero.
    for (int i = 0; i < 10; i++) apply_step("integ", 1'b1, 5);
    check_val("integ.v40", {24'd0, membrane_potential}, 40);
    for (int i = 0; i < 3; i++) apply_step("neg", 1'b1, -16);
    check_val("neg.v0", {24'd0, membrane_potential}, 0);

    // Fire followed by two ignored steps.
    set_cfg(20, 0, 2);
    apply_step("fire1", 1'b1, 8);
    apply_step("fire2", 1'b1, 8);
    apply_step("fire3", 1'b1, 8);
    check_val("fire3.spk", {31'd0, spike_out}, 1);
    apply_step("refr1", 1'b1, 8);
    check_val("refr1.spk", {31'd0, spike_out}, 0);
    apply_step("refr2", 1'b1, 8);
    apply_step("resume", 1'b1, 8);
    check_val("resume.v8", {24'd0, membrane_potential}, 8);

    // Enable low holds state and keeps spike low.
    for (int i = 0; i < 5; i++) apply_step("gate", 1'b0, 15);
    check_val("gate.v8", {24'd0, membrane_potential}, 8);

    // Zero threshold with no refractory fires every step.
    set_cfg(0, 0, 0);
    for (int i = 0; i < 4; i++) apply_step("thr0", 1'b1, i - 2);

    // Saturation: climb to 245 then approach 255 without firing.
    do_reset("rst_a");
    set_cfg(255, 0, 0);
    for (int i = 0; i < 16; i++) apply_step("climb", 1'b1, 15);
    apply_step("climb245", 1'b1, 5);
    apply_step("sat253", 1'b1, 8);
    check_val("sat253.v", {24'd0, membrane_potential}, 253);
    apply_step("sat254", 1'b1, 1);
    check_val("sat254.v", {24'd0, membrane_potential}, 254);

    // Clamp to 255 reaches the maximum threshold and fires.
    do_reset("rst_b");
    for (int i = 0; i < 16; i++) apply_step("climb", 1'b1, 15);
    apply_step("v250", 1'b1, 10);
    apply_step("clampfire", 1'b1, 15);
    check_val("clampfire.spk", {31'd0, spike_out}, 1);

    // Reset in the middle of a refractory period, then restart.
    set_cfg(20, 0, 5);
    do_reset("rst_c");
    for (int i = 0; i < 3; i++) apply_step("prefire", 1'b1, 8);
    apply_step("midrefr", 1'b1, 8);
    do_reset("rst_midrefr");
    set_cfg(100, 0, 0);
    apply_step("after_rst", 1'b1, 3);
    check_val("after_rst.v3", {24'd0, membrane_potential}, 3);

    // Randomized steps; config changes every step to exercise per-step sampling.
    for (int i = 0; i < 400; i++) begin
      int cur;
      int thr;
      if ($urandom_range(0, 99) < 2) do_reset("rnd_rst");
      thr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(20, 90));
      set_cfg(thr, int'($urandom_range(0, 15)) / 3, int'($urandom_range(0, 15)) / 2);
      cur = int'($urandom_range(0, 31)) - 16;
      apply_step("rnd", ($urandom_range(0, 3) != 0), cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
